// File: rtl/regfile_wb_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler_pkg
// Purpose  : Shared constants and types for the register-file write-port
//            scheduler and its busy-register scoreboard.
// Contents : c_XLEN, c_REG_ADDR_W, c_NUM_REGS, c_STARVE_LIMIT,
//            src_sel_e (write-port source), rr_sel_e (round-robin pointer)
// Revision : 1.0 - initial release
// ============================================================================
package regfile_wb_scheduler_pkg;

  localparam int c_XLEN         = 32;
  localparam int c_REG_ADDR_W   = 5;
  localparam int c_NUM_REGS     = 32;
  localparam int c_STARVE_LIMIT = 4;
  localparam int c_STARVE_CNT_W = 4;   // holds STARVE_LIMIT-1 for limits up to 15

  // Which producer owns the write port in the current cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_MC0  = 2'd2,
    SRC_MC1  = 2'd3
  } src_sel_e;

  // Preferred multi-cycle unit when both are requesting
  typedef enum logic {
    RR_MC0 = 1'b0,
    RR_MC1 = 1'b1
  } rr_sel_e;

endpackage : regfile_wb_scheduler_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Busy-register scoreboard for results still owed by the
//            multi-cycle units, with three hazard lookups.
// Ports    : clk_i, rst_i (async, active-low)
//            set_en_i/set_addr_i  - mark a register busy at the clock edge
//            clr_en_i/clr_addr_i  - accepted mc write, clears the register
//            rs1_i/rs2_i/rd_i     - lookup addresses
//            hit_rs1_o/hit_rs2_o/hit_rd_o - busy and not being written now
//            busy_o               - full busy vector (bit 0 always 0)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_wb_scheduler_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    set_en_i,
  input  logic [c_REG_ADDR_W-1:0] set_addr_i,
  input  logic                    clr_en_i,
  input  logic [c_REG_ADDR_W-1:0] clr_addr_i,
  input  logic [c_REG_ADDR_W-1:0] rs1_i,
  input  logic [c_REG_ADDR_W-1:0] rs2_i,
  input  logic [c_REG_ADDR_W-1:0] rd_i,
  output logic                    hit_rs1_o,
  output logic                    hit_rs2_o,
  output logic                    hit_rd_o,
  output logic [c_NUM_REGS-1:0]   busy_o
);

  // x0 never holds a pending result, so only bits 1..31 are stored
  logic [c_NUM_REGS-1:1] r_busy;

  for (genvar gi = 1; gi < c_NUM_REGS; gi++) begin : g_busy
    localparam logic [c_REG_ADDR_W-1:0] c_IDX = c_REG_ADDR_W'(gi);
    // Set is tested first: a new issue to a register retiring this cycle
    // must leave the register busy for the new owner.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        r_busy[gi] <= 1'b0;
      end else if (set_en_i && (set_addr_i == c_IDX)) begin
        r_busy[gi] <= 1'b1;
      end else if (clr_en_i && (clr_addr_i == c_IDX)) begin
        r_busy[gi] <= 1'b0;
      end
    end
  end

  assign busy_o = {r_busy, 1'b0};

  // A register being written by an mc unit this cycle is not a hazard:
  // the register file's write-through bypass supplies the new value.
  function automatic logic f_hit(input logic [c_NUM_REGS-1:0]   busy,
                                 input logic [c_REG_ADDR_W-1:0] r,
                                 input logic                    clr_en,
                                 input logic [c_REG_ADDR_W-1:0] clr_addr);
    f_hit = busy[r] && (r != '0) && !(clr_en && (clr_addr == r));
  endfunction

  assign hit_rs1_o = f_hit(busy_o, rs1_i, clr_en_i, clr_addr_i);
  assign hit_rs2_o = f_hit(busy_o, rs2_i, clr_en_i, clr_addr_i);
  assign hit_rd_o  = f_hit(busy_o, rd_i,  clr_en_i, clr_addr_i);

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler
// Purpose  : Schedules the single register-file write port among the
//            in-order WB stage and two multi-cycle units (mc0 divider,
//            mc1 load/miss), tracks registers still owed by the mc units
//            and raises the ID-stage hazard stall.
// Ports    : clk_i, rst_i (async, active-low)
//            wb_valid_i/wb_addr_i/wb_data_i         - pipeline writeback
//            mcN_valid_i/mcN_addr_i/mcN_data_i      - mc results (N=0,1)
//            mcN_ready_o                            - mc result accepted
//            issue_i/issue_rd_i                     - ID issue to an mc unit
//            id_rs1_i/id_rs2_i/id_rd_i              - ID operand addresses
//            stall_o                                - ID hazard stall
//            wb_hold_o                              - no WB next cycle
//            reg_write_o/reg_addr_o/reg_data_o      - register-file port
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int XLEN         = c_XLEN,
  parameter int STARVE_LIMIT = c_STARVE_LIMIT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wb_valid_i,
  input  logic [c_REG_ADDR_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]         wb_data_i,
  input  logic                    mc0_valid_i,
  input  logic [c_REG_ADDR_W-1:0] mc0_addr_i,
  input  logic [XLEN-1:0]         mc0_data_i,
  output logic                    mc0_ready_o,
  input  logic                    mc1_valid_i,
  input  logic [c_REG_ADDR_W-1:0] mc1_addr_i,
  input  logic [XLEN-1:0]         mc1_data_i,
  output logic                    mc1_ready_o,
  input  logic                    issue_i,
  input  logic [c_REG_ADDR_W-1:0] issue_rd_i,
  input  logic [c_REG_ADDR_W-1:0] id_rs1_i,
  input  logic [c_REG_ADDR_W-1:0] id_rs2_i,
  input  logic [c_REG_ADDR_W-1:0] id_rd_i,
  output logic                    stall_o,
  output logic                    wb_hold_o,
  output logic                    reg_write_o,
  output logic [c_REG_ADDR_W-1:0] reg_addr_o,
  output logic [XLEN-1:0]         reg_data_o
);

  localparam logic [c_STARVE_CNT_W-1:0] c_STARVE_LAST =
    c_STARVE_CNT_W'(STARVE_LIMIT - 1);

  src_sel_e                    w_grant;
  rr_sel_e                     r_rr_ptr;
  logic [c_STARVE_CNT_W-1:0]   r_starve_cnt;
  logic                        r_wb_hold;
  logic                        w_starve_cond;
  logic                        w_mc_acc;
  logic [c_REG_ADDR_W-1:0]     w_mc_addr;
  logic                        w_hit_rs1;
  logic                        w_hit_rs2;
  logic                        w_hit_rd;
  logic [c_NUM_REGS-1:0]       w_busy;

  // --------------------------------------------------------------------------
  // Grant: WB first, then the two mc units round-robin. A lone mc request
  // wins regardless of the pointer.
  // --------------------------------------------------------------------------
  always_comb begin
    w_grant = SRC_NONE;
    if (wb_valid_i) begin
      w_grant = SRC_WB;
    end else if (mc0_valid_i && mc1_valid_i) begin
      w_grant = (r_rr_ptr == RR_MC0) ? SRC_MC0 : SRC_MC1;
    end else if (mc0_valid_i) begin
      w_grant = SRC_MC0;
    end else if (mc1_valid_i) begin
      w_grant = SRC_MC1;
    end
  end

  assign mc0_ready_o = (w_grant == SRC_MC0);
  assign mc1_ready_o = (w_grant == SRC_MC1);
  assign w_mc_acc    = mc0_ready_o || mc1_ready_o;
  assign w_mc_addr   = mc1_ready_o ? mc1_addr_i : mc0_addr_i;

  // --------------------------------------------------------------------------
  // Write-port mux; all zero when nobody owns the port
  // --------------------------------------------------------------------------
  always_comb begin
    reg_addr_o = '0;
    reg_data_o = '0;
    case (w_grant)
      SRC_WB: begin
        reg_addr_o = wb_addr_i;
        reg_data_o = wb_data_i;
      end
      SRC_MC0: begin
        reg_addr_o = mc0_addr_i;
        reg_data_o = mc0_data_i;
      end
      SRC_MC1: begin
        reg_addr_o = mc1_addr_i;
        reg_data_o = mc1_data_i;
      end
      default: begin
        reg_addr_o = '0;
        reg_data_o = '0;
      end
    endcase
  end

  assign reg_write_o = (w_grant != SRC_NONE) && (reg_addr_o != '0);

  // --------------------------------------------------------------------------
  // Round-robin pointer: after an mc grant, prefer the other unit
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rr_ptr <= RR_MC0;
    end else if (w_grant == SRC_MC0) begin
      r_rr_ptr <= RR_MC1;
    end else if (w_grant == SRC_MC1) begin
      r_rr_ptr <= RR_MC0;
    end
  end

  // --------------------------------------------------------------------------
  // Starvation guard: count consecutive WB grants while an mc result waits;
  // on the last tolerated one, hold WB off for exactly one cycle so that an
  // mc unit gets the port.
  // --------------------------------------------------------------------------
  assign w_starve_cond = (w_grant == SRC_WB) && (mc0_valid_i || mc1_valid_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_starve_cnt <= '0;
      r_wb_hold    <= 1'b0;
    end else if (w_starve_cond && (r_starve_cnt == c_STARVE_LAST)) begin
      r_starve_cnt <= '0;
      r_wb_hold    <= 1'b1;
    end else if (w_starve_cond) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
      r_wb_hold    <= 1'b0;
    end else begin
      r_starve_cnt <= '0;
      r_wb_hold    <= 1'b0;
    end
  end

  assign wb_hold_o = r_wb_hold;

  // --------------------------------------------------------------------------
  // Scoreboard and ID stall
  // --------------------------------------------------------------------------
  regfile_scoreboard u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .set_en_i   (issue_i && (issue_rd_i != '0)),
    .set_addr_i (issue_rd_i),
    .clr_en_i   (w_mc_acc),
    .clr_addr_i (w_mc_addr),
    .rs1_i      (id_rs1_i),
    .rs2_i      (id_rs2_i),
    .rd_i       (id_rd_i),
    .hit_rs1_o  (w_hit_rs1),
    .hit_rs2_o  (w_hit_rs2),
    .hit_rd_o   (w_hit_rd),
    .busy_o     (w_busy)
  );

  // WAW only matters when the ID instruction actually issues
  assign stall_o = w_hit_rs1 || w_hit_rs2 || (w_hit_rd && issue_i);

  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
  a_wb_to_busy : assert property (@(posedge clk_i) disable iff (!rst_i)
    wb_valid_i |-> !w_busy[wb_addr_i])
    else $error("pipeline writeback to busy register %0d", wb_addr_i);

  a_issue_stalled : assert property (@(posedge clk_i) disable iff (!rst_i)
    issue_i |-> !stall_o)
    else $error("issue while stalled");

  a_mc_not_busy : assert property (@(posedge clk_i) disable iff (!rst_i)
    (w_mc_acc && (w_mc_addr != '0)) |-> w_busy[w_mc_addr])
    else $error("mc write to non-busy register %0d", w_mc_addr);

endmodule : regfile_wb_scheduler
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_scheduler
// Purpose  : Self-checking bench for regfile_wb_scheduler: directed scenarios
//            with literal expectations plus randomized traffic compared each
//            cycle against a behavioural model of the scheduling rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic            wb_valid_i, mc0_valid_i, mc1_valid_i, issue_i;
  logic [4:0]      wb_addr_i, mc0_addr_i, mc1_addr_i, issue_rd_i;
  logic [4:0]      id_rs1_i, id_rs2_i, id_rd_i;
  logic [XLEN-1:0] wb_data_i, mc0_data_i, mc1_data_i;
  logic            mc0_ready_o, mc1_ready_o, stall_o, wb_hold_o, reg_write_o;
  logic [4:0]      reg_addr_o;
  logic [XLEN-1:0] reg_data_o;

  always #5 clk_i = ~clk_i;

  regfile_wb_scheduler #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .mc0_valid_i(mc0_valid_i), .mc0_addr_i(mc0_addr_i), .mc0_data_i(mc0_data_i),
    .mc0_ready_o(mc0_ready_o),
    .mc1_valid_i(mc1_valid_i), .mc1_addr_i(mc1_addr_i), .mc1_data_i(mc1_data_i),
    .mc1_ready_o(mc1_ready_o),
    .issue_i(issue_i), .issue_rd_i(issue_rd_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .stall_o(stall_o), .wb_hold_o(wb_hold_o),
    .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  bit   m_busy [32];
  int   m_last_mc;      // last mc unit granted; the other one is preferred
  int   m_run;          // length of the current WB-over-waiting-mc run
  bit   m_hold;
  int   e_src;          // 0 none, 1 wb, 2 mc0, 3 mc1
  logic            e_we, e_r0, e_r1, e_stall;
  logic [4:0]      e_addr;
  logic [XLEN-1:0] e_data;

  function automatic bit m_hit(input logic [4:0] r);
    bit         acc = (e_src == 2) || (e_src == 3);
    logic [4:0] aa  = (e_src == 2) ? mc0_addr_i : mc1_addr_i;
    return m_busy[r] && (r != 0) && !(acc && (aa == r));
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_last_mc = 1;
    m_run     = 0;
    m_hold    = 1'b0;
  endtask

  task automatic model_eval();
    if (wb_valid_i)                      e_src = 1;
    else if (mc0_valid_i && mc1_valid_i) e_src = (m_last_mc == 0) ? 3 : 2;
    else if (mc0_valid_i)                e_src = 2;
    else if (mc1_valid_i)                e_src = 3;
    else                                 e_src = 0;
    case (e_src)
      1:       begin e_addr = wb_addr_i;  e_data = wb_data_i;  end
      2:       begin e_addr = mc0_addr_i; e_data = mc0_data_i; end
      3:       begin e_addr = mc1_addr_i; e_data = mc1_data_i; end
      default: begin e_addr = '0;         e_data = '0;         end
    endcase
    e_we    = (e_src != 0) && (e_addr != 0);
    e_r0    = (e_src == 2);
    e_r1    = (e_src == 3);
    e_stall = m_hit(id_rs1_i) || m_hit(id_rs2_i) || (m_hit(id_rd_i) && issue_i);
  endtask

  task automatic model_commit();
    bit cond;
    if (e_src >= 2) begin
      if (e_addr != 0) m_busy[e_addr] = 1'b0;
      m_last_mc = e_src - 2;
    end
    if (issue_i && issue_rd_i != 0) m_busy[issue_rd_i] = 1'b1;
    cond   = (e_src == 1) && (mc0_valid_i || mc1_valid_i);
    m_run  = cond ? m_run + 1 : 0;
    m_hold = cond && (m_run % LIMIT == 0);
  endtask

  // ---------------- checking ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs are set at the negedge; outputs settle and are sampled #1 later
  task automatic step();
    #1;
    model_eval();
    vectors++;
    cmp("reg_write", 32'(reg_write_o), 32'(e_we));
    cmp("reg_addr",  32'(reg_addr_o),  32'(e_addr));
    cmp("reg_data",  reg_data_o,       e_data);
    cmp("mc0_ready", 32'(mc0_ready_o), 32'(e_r0));
    cmp("mc1_ready", 32'(mc1_ready_o), 32'(e_r1));
    cmp("stall",     32'(stall_o),     32'(e_stall));
    cmp("wb_hold",   32'(wb_hold_o),   32'(m_hold));
  endtask

  task automatic tick();
    model_commit();
    @(negedge clk_i);
  endtask

  task automatic idle();
    wb_valid_i = 0; wb_addr_i = 0; wb_data_i = 0;
    mc0_valid_i = 0; mc0_addr_i = 0; mc0_data_i = 0;
    mc1_valid_i = 0; mc1_addr_i = 0; mc1_data_i = 0;
    issue_i = 0; issue_rd_i = 0; id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    idle(); issue_i = 1; issue_rd_i = rd; id_rd_i = rd;
    step(); tick();
  endtask

  // Asynchronous reset asserted mid-cycle; mc units reset alongside
  task automatic do_reset(input logic [4:0] probe_rs1);
    rst_i = 0;
    idle();
    id_rs1_i = probe_rs1;
    model_reset();
    #1;
    cmp("rst_stall",     32'(stall_o),     32'd0);
    cmp("rst_reg_write", 32'(reg_write_o), 32'd0);
    cmp("rst_wb_hold",   32'(wb_hold_o),   32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1;
  endtask

  // ---------------- random-phase mc units ----------------
  int              q [2][$];
  bit              pv [2];
  logic [4:0]      pa [2];
  logic [XLEN-1:0] pd [2];

  initial begin
    idle();
    model_reset();
    @(negedge clk_i);
    step();
    cmp("init_ready0", 32'(mc0_ready_o), 32'd0);
    tick();
    rst_i = 1;

    // ---- reset mid-traffic with register 5 busy ----
    do_issue(5'd5);
    idle(); id_rs1_i = 5; step();
    cmp("busy5_stall", 32'(stall_o), 32'd1);
    tick();
    idle(); wb_valid_i = 1; wb_addr_i = 3; wb_data_i = 32'hAA;
    mc1_valid_i = 1; mc1_addr_i = 5; mc1_data_i = 32'hBB; id_rs1_i = 5;
    step();
    do_reset(5'd5);
    idle(); id_rs1_i = 5; step();
    cmp("post_rst_stall", 32'(stall_o), 32'd0);
    tick();

    // ---- round-robin: pointer starts at mc0 ----
    do_issue(5'd4);  do_issue(5'd6); do_issue(5'd8);
    do_issue(5'd10); do_issue(5'd14);
    idle(); mc0_valid_i = 1; mc0_addr_i = 4;  mc0_data_i = 32'h104;
            mc1_valid_i = 1; mc1_addr_i = 6;  mc1_data_i = 32'h106;
    step(); cmp("rr1_ready0", 32'(mc0_ready_o), 32'd1); cmp("rr1_addr", 32'(reg_addr_o), 32'd4); tick();
    mc0_addr_i = 8; mc0_data_i = 32'h108;
    step(); cmp("rr2_ready1", 32'(mc1_ready_o), 32'd1); cmp("rr2_addr", 32'(reg_addr_o), 32'd6); tick();
    mc1_addr_i = 10; mc1_data_i = 32'h10A;
    step(); cmp("rr3_ready0", 32'(mc0_ready_o), 32'd1); cmp("rr3_addr", 32'(reg_addr_o), 32'd8); tick();
    mc0_addr_i = 14; mc0_data_i = 32'h10E;
    step(); cmp("rr4_ready1", 32'(mc1_ready_o), 32'd1); cmp("rr4_data", reg_data_o, 32'h10A); tick();
    idle(); mc0_valid_i = 1; mc0_addr_i = 14; mc0_data_i = 32'h10E;
    step(); cmp("rr5_lone", 32'(mc0_ready_o), 32'd1); tick();

    // ---- WB priority over mc0 ----
    do_issue(5'd7);
    idle(); wb_valid_i = 1; wb_addr_i = 3; wb_data_i = 32'h11;
    mc0_valid_i = 1; mc0_addr_i = 7; mc0_data_i = 32'h22;
    step();
    cmp("prio_addr", 32'(reg_addr_o), 32'd3);
    cmp("prio_data", reg_data_o, 32'h11);
    cmp("prio_ready0", 32'(mc0_ready_o), 32'd0);
    tick();
    wb_valid_i = 0;
    step();
    cmp("prio2_addr", 32'(reg_addr_o), 32'd7);
    cmp("prio2_data", reg_data_o, 32'h22);
    cmp("prio2_ready0", 32'(mc0_ready_o), 32'd1);
    tick();

    // ---- starvation: hold after the 4th WB grant with mc1 waiting ----
    do_issue(5'd12);
    for (int k = 0; k < 4; k++) begin
      idle(); wb_valid_i = 1; wb_addr_i = 5'((k % 3) + 1); wb_data_i = 32'h50 + k;
      mc1_valid_i = 1; mc1_addr_i = 12; mc1_data_i = 32'hC12;
      step();
      cmp("starve_nohold", 32'(wb_hold_o), 32'd0);
      tick();
    end
    idle(); mc1_valid_i = 1; mc1_addr_i = 12; mc1_data_i = 32'hC12;
    step();
    cmp("starve_hold", 32'(wb_hold_o), 32'd1);
    cmp("starve_mc1", 32'(mc1_ready_o), 32'd1);
    tick();
    idle(); step(); cmp("starve_hold_once", 32'(wb_hold_o), 32'd0); tick();

    // ---- scoreboard: RAW stall and same-cycle bypass ----
    do_issue(5'd9);
    idle(); id_rs1_i = 9; step(); cmp("sb_stall", 32'(stall_o), 32'd1); tick();
    idle(); id_rs1_i = 9; mc0_valid_i = 1; mc0_addr_i = 9; mc0_data_i = 32'h99;
    step(); cmp("sb_bypass_stall", 32'(stall_o), 32'd0); cmp("sb_bypass_we", 32'(reg_write_o), 32'd1); tick();
    idle(); id_rs1_i = 9; step(); cmp("sb_cleared", 32'(stall_o), 32'd0); tick();

    // ---- set wins over clear on the same register ----
    do_issue(5'd9);
    idle(); mc1_valid_i = 1; mc1_addr_i = 9; mc1_data_i = 32'h91;
    issue_i = 1; issue_rd_i = 9; id_rd_i = 9;
    step(); cmp("setwin_nostall", 32'(stall_o), 32'd0); cmp("setwin_ready1", 32'(mc1_ready_o), 32'd1); tick();
    idle(); id_rs1_i = 9; step(); cmp("setwin_busy", 32'(stall_o), 32'd1); tick();
    idle(); mc0_valid_i = 1; mc0_addr_i = 9; mc0_data_i = 32'h92; step(); tick();

    // ---- x0: never busy, never written ----
    do_issue(5'd0);
    idle(); id_rs1_i = 0; mc0_valid_i = 1; mc0_addr_i = 0; mc0_data_i = 32'h55;
    step(); cmp("x0_we", 32'(reg_write_o), 32'd0); cmp("x0_ready", 32'(mc0_ready_o), 32'd1); cmp("x0_stall", 32'(stall_o), 32'd0); tick();
    idle(); wb_valid_i = 1; wb_addr_i = 0; wb_data_i = 32'h66;
    step(); cmp("x0_wb_we", 32'(reg_write_o), 32'd0); tick();

    // ---- randomized traffic ----
    for (int u = 0; u < 2; u++) begin q[u].delete(); pv[u] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int         iu;
      logic [4:0] rd;
      if (cyc == 1500) begin
        do_reset(5'($urandom_range(0, 31)));
        for (int u = 0; u < 2; u++) begin q[u].delete(); pv[u] = 0; end
      end
      idle();
      for (int u = 0; u < 2; u++)
        if (!pv[u] && q[u].size() > 0 && $urandom_range(0, 2) == 0) begin
          pv[u] = 1; pa[u] = 5'(q[u][0]); pd[u] = $urandom;
        end
      mc0_valid_i = pv[0]; mc0_addr_i = pv[0] ? pa[0] : 5'd0; mc0_data_i = pv[0] ? pd[0] : '0;
      mc1_valid_i = pv[1]; mc1_addr_i = pv[1] ? pa[1] : 5'd0; mc1_data_i = pv[1] ? pd[1] : '0;
      if (!m_hold && $urandom_range(0, 1) == 1) begin
        wb_valid_i = 1;
        wb_addr_i  = 5'($urandom_range(0, 31));
        if (m_busy[wb_addr_i]) wb_addr_i = 0;
        wb_data_i  = $urandom;
      end
      id_rs1_i = 5'($urandom_range(0, 31));
      id_rs2_i = 5'($urandom_range(0, 31));
      iu = $urandom_range(0, 1);
      rd = 5'($urandom_range(0, 31));
      id_rd_i = rd; issue_rd_i = rd;
      model_eval();
      if (q[iu].size() < 2 && $urandom_range(0, 1) == 1 &&
          !m_hit(id_rs1_i) && !m_hit(id_rs2_i) && !m_hit(rd))
        issue_i = 1;
      step();
      if (e_src == 2) begin void'(q[0].pop_front()); pv[0] = 0; end
      if (e_src == 3) begin void'(q[1].pop_front()); pv[1] = 0; end
      if (issue_i) q[iu].push_back(int'(rd));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_regfile_wb_scheduler
`default_nettype wire

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Schedules the single register-file write port among three producers:
  - in-order pipeline writeback (WB stage)
  - two multi-cycle units (mc0 = divider, mc1 = load/miss unit)
- Keeps a busy-register scoreboard for results still owed by the multi-cycle units, and generates the ID-stage hazard stall.
- Sits between the WB stage / multi-cycle units and the register file write port (RegWrite/RDaddr/RDdata).

Parameters:
- XLEN, 32, data width of the write port.
- STARVE_LIMIT, 4, consecutive cycles of pipeline-WB port ownership tolerated while any mc request waits (range 1..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- wb_valid_i  in  1  pipeline writeback request (cannot be back-pressured except via wb_hold_o)
- wb_addr_i  in  5  pipeline rd
- wb_data_i  in  XLEN  pipeline result
- mc0_valid_i  in  1  mc0 result valid
- mc0_addr_i  in  5  mc0 rd
- mc0_data_i  in  XLEN  mc0 result
- mc0_ready_o  out  1  mc0 result accepted this cycle
- mc1_valid_i  in  1  mc1 result valid
- mc1_addr_i  in  5  mc1 rd
- mc1_data_i  in  XLEN  mc1 result
- mc1_ready_o  out  1  mc1 result accepted this cycle
- issue_i  in  1  ID issues an instruction to an mc unit this cycle
- issue_rd_i  in  5  destination of that instruction
- id_rs1_i  in  5  ID source 1
- id_rs2_i  in  5  ID source 2
- id_rd_i  in  5  ID destination
- stall_o  out  1  ID must stall (RAW/WAW on busy register)
- wb_hold_o  out  1  pipeline must not present a writeback next cycle
- reg_write_o  out  1  register-file write enable
- reg_addr_o  out  5  register-file write address
- reg_data_o  out  XLEN  register-file write data

Behaviour:
- Reset: rst_i is asynchronous, active-low; clk_i is the clock. While rst_i is low:
  - busy scoreboard = 0, RR pointer = mc0, starve counter = 0, wb_hold_o = 0
  - all combinational outputs evaluate with cleared state
  - a mid-operation reset drops all pending bookkeeping; in-flight mc units are reset by the same rst_i.
- Grant (combinational, zero latency to the write port):
  - wb_valid_i has priority over both mc units.
  - If wb_valid_i is low, the mc units are arbitrated round-robin. The RR pointer points to the preferred unit and toggles to the other unit after each mc grant.
  - A lone valid mc unit is granted regardless of the pointer.
  - mcN_ready_o = 1 only in the cycle mcN is granted; the handshake completes when valid & ready. Valid must hold with stable addr/data until ready.
- Write port:
  - reg_write_o = granted request valid and its addr != 0.
  - reg_addr_o / reg_data_o are muxed from the granted source, and are 0 when there is no grant.
- Starvation:
  - The counter increments each cycle the WB stage is granted while any mc valid is pending. It clears on any cycle without that condition.
  - When counter == STARVE_LIMIT-1 and the condition holds, wb_hold_o registers to 1 for exactly one cycle and the counter clears.
  - The pipeline guarantees wb_valid_i = 0 in a hold cycle, so an mc unit is granted.
- Scoreboard busy[31:1]; busy[0] is hard-wired 0:
  - Set: issue_i & issue_rd_i != 0 sets busy[issue_rd_i] at the clock edge.
  - Clear: an accepted mc handshake clears busy[addr].
  - Set and clear of the same index in the same cycle: set wins.
- stall_o = hit(id_rs1_i) | hit(id_rs2_i) | (hit(id_rd_i) & issue_i). hit(r) = busy[r] & r != 0 & !(mc write to r accepted this cycle). The register file's same-cycle write bypass supplies the data in that case.
- Assertions:
  - A pipeline writeback to a busy register is an error, as is issue_i while stall_o = 1.
  - An accepted mc write to a non-busy register is an error.

Decomposition:
- Shared package: XLEN, REG_ADDR_W = 5, NUM_REGS = 32, a source-select enum {SRC_NONE, SRC_WB, SRC_MC0, SRC_MC1}, and the STARVE_LIMIT default.
- One sub-module, regfile_scoreboard: busy vector, set/clear, and the three hit lookups with same-cycle-clear bypass.
- The arbiter, starve counter and write mux stay in the top module.

Test Plan:
- Reset: rst_i low mid-traffic with busy[5] = 1 -> busy cleared, stall_o = 0, reg_write_o = 0 asynchronously; RR pointer reads mc0 after release.
- Priority: wb_valid(addr 3, 0x11), mc0_valid(addr 7, 0x22) together -> reg_addr_o = 3, mc0_ready_o = 0. Next cycle with wb idle -> reg_addr_o = 7, data 0x22, mc0_ready_o = 1.
- Round-robin: mc0 and mc1 held valid with wb idle for 4 cycles -> grants mc0, mc1, mc0, mc1.
- Starvation (STARVE_LIMIT = 4): wb_valid every cycle with mc1 pending -> wb_hold_o = 1 after the 4th WB grant. The following cycle (wb idle) grants mc1.
- Scoreboard: issue rd = 9 -> next cycle id_rs1 = 9 gives stall_o = 1. In the cycle mc0 writes 9, stall_o = 0 and reg_write_o = 1. The cycle after, busy[9] = 0.
- Corner cases:
  - issue rd = 9 in the same cycle mc1 retires 9 -> busy[9] stays 1.
  - rd = 0 issue/write -> no busy bit set and reg_write_o = 0.
